// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared RSA datapath types: widths, iteration guard, FSM encoding, coefficient type
package rsa_pkg;

    localparam int WIDTH    = 16;
    localparam int MAX_ITER = 24;
    localparam int ITER_W   = 5;
    localparam int COEF_W   = WIDTH + 2;

    typedef logic [WIDTH-1:0]         word_t;
    typedef logic signed [COEF_W-1:0] coef_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_STEP  = 3'd2,
        ST_FINAL = 3'd3,
        ST_CHECK = 3'd4
    } inv_state_t;

endpackage

// File: rtl/mod_inverse_if.sv
// rtl/mod_inverse_if.sv - request/result bundle of the modular inverse unit (check_err with MOD_INV_CHECK_EN)
interface mod_inverse_if;
    import rsa_pkg::*;

    word_t a;
    word_t n;
    logic  ready;
    word_t result;
    logic  valid;
    logic  no_inverse;
    logic  busy;
`ifdef MOD_INV_CHECK_EN
    logic  check_err;
`endif

    modport master (
        output a, n, ready,
        input  result, valid, no_inverse, busy
`ifdef MOD_INV_CHECK_EN
        , input check_err
`endif
    );

    modport slave (
        input  a, n, ready,
        output result, valid, no_inverse, busy
`ifdef MOD_INV_CHECK_EN
        , output check_err
`endif
    );

endinterface

// File: rtl/mod_inv_step.sv
// rtl/mod_inv_step.sv - one combinational extended-Euclid quotient step on remainders and coefficients
module mod_inv_step
    import rsa_pkg::*;
(
    input  word_t r0,
    input  word_t r1,
    input  coef_t t0,
    input  coef_t t1,
    output word_t r0_next,
    output word_t r1_next,
    output coef_t t0_next,
    output coef_t t1_next
);

    word_t                    divisor;
    word_t                    q;
    logic signed [2*COEF_W-3:0] qt;

    always_comb begin
        // divisor is never 0 when the step is used; the mux keeps the divider defined
        divisor = (r1 == '0) ? word_t'(1) : r1;
        q       = r0 / divisor;
        r0_next = r1;
        r1_next = r0 % divisor;
        qt      = $signed({{(COEF_W-2){1'b0}}, q}) * $signed({{(WIDTH){t1[COEF_W-1]}}, t1});
        t0_next = t1;
        t1_next = t0 - $signed(qt[COEF_W-1:0]);
    end

endmodule

// File: rtl/mod_inverse.sv
// rtl/mod_inverse.sv - sequential 16-bit modular inverse by extended Euclid; MOD_INV_CHECK_EN adds a CHECK state
module mod_inverse
    import rsa_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    mod_inverse_if.slave  bus
);

    inv_state_t        state;
    inv_state_t        next_state;
    word_t             a_q;
    word_t             n_q;
    word_t             r0;
    word_t             r1;
    coef_t             t0;
    coef_t             t1;
    logic [ITER_W-1:0] iter;
    word_t             result_q;
    logic              valid_q;
    logic              no_inv_q;

    word_t             r0_nx;
    word_t             r1_nx;
    coef_t             t0_nx;
    coef_t             t1_nx;
    word_t             n_div;
    logic              step_go;
    logic              fail;
    coef_t             t_adj;
    word_t             fin_result;

    mod_inv_step u_step (
        .r0      (r0),
        .r1      (r1),
        .t0      (t0),
        .t1      (t1),
        .r0_next (r0_nx),
        .r1_next (r1_nx),
        .t0_next (t0_nx),
        .t1_next (t1_nx)
    );

    always_comb begin
        n_div      = (n_q == '0) ? word_t'(1) : n_q;
        step_go    = (r1 != '0) && (iter < ITER_W'(MAX_ITER));
        // r1 still nonzero in FINAL means the iteration guard stopped the loop
        fail       = (r0 != word_t'(1)) || (n_q < word_t'(2)) || (r1 != '0);
        t_adj      = t0 + $signed({2'b00, n_q});
        fin_result = fail ? '0 : (t0[COEF_W-1] ? t_adj[WIDTH-1:0] : t0[WIDTH-1:0]);
    end

`ifdef MOD_INV_CHECK_EN
    logic [2*WIDTH-1:0] chk_prod;
    logic [2*WIDTH-1:0] chk_mod;
    logic               check_err_q;

    always_comb begin
        chk_prod = a_q * result_q;
        chk_mod  = chk_prod % {{WIDTH{1'b0}}, n_div};
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (bus.ready) next_state = ST_INIT;
            ST_INIT:  next_state = ST_STEP;
            ST_STEP:  if (!step_go) next_state = ST_FINAL;
`ifdef MOD_INV_CHECK_EN
            ST_FINAL: next_state = ST_CHECK;
            ST_CHECK: next_state = ST_IDLE;
`else
            ST_FINAL: next_state = ST_IDLE;
`endif
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q      <= '0;
            n_q      <= '0;
            r0       <= '0;
            r1       <= '0;
            t0       <= '0;
            t1       <= '0;
            iter     <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            no_inv_q <= 1'b0;
`ifdef MOD_INV_CHECK_EN
            check_err_q <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.ready) begin
                        a_q <= bus.a;
                        n_q <= bus.n;
                    end
                end
                ST_INIT: begin
                    r0   <= n_q;
                    r1   <= (n_q < word_t'(2)) ? '0 : (a_q % n_div);
                    t0   <= '0;
                    t1   <= coef_t'(1);
                    iter <= '0;
                end
                ST_STEP: begin
                    if (step_go) begin
                        r0   <= r0_nx;
                        r1   <= r1_nx;
                        t0   <= t0_nx;
                        t1   <= t1_nx;
                        iter <= iter + 1'b1;
                    end
                end
                ST_FINAL: begin
                    result_q <= fin_result;
                    no_inv_q <= fail;
`ifndef MOD_INV_CHECK_EN
                    valid_q  <= 1'b1;
`endif
                end
`ifdef MOD_INV_CHECK_EN
                ST_CHECK: begin
                    check_err_q <= !no_inv_q && (chk_mod != {{(2*WIDTH-1){1'b0}}, 1'b1});
                    valid_q     <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.result     = result_q;
    assign bus.valid      = valid_q;
    assign bus.no_inverse = no_inv_q;
    assign bus.busy       = (state != ST_IDLE);
`ifdef MOD_INV_CHECK_EN
    assign bus.check_err  = check_err_q;
`endif

endmodule

// File: tb/tb_mod_inverse.sv
// tb/tb_mod_inverse.sv - directed and random checks of mod_inverse against a brute-force inverse model
module tb_mod_inverse;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    mod_inverse_if bus ();

    mod_inverse dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout observed running expected finished");
        $fatal(1, "simulation time limit");
    end

`ifdef MOD_INV_CHECK_EN
    localparam int EXTRA_LAT = 1;
`else
    localparam int EXTRA_LAT = 0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: inverse found by exhaustive search, Euclid step count by plain division loop
    task automatic ref_model(input int av, input int nv, output int res, output int noinv, output int k);
        longint r0, r1, tmp;
        res = 0; noinv = 1; k = 0;
        if (nv < 2) return;
        r0 = nv; r1 = av % nv;
        while (r1 != 0) begin
            tmp = r0 % r1; r0 = r1; r1 = tmp; k++;
        end
        if (r0 != 1) return;
        for (int x = 1; x < nv; x++)
            if ((longint'(av) * x) % nv == 1) begin res = x; noinv = 0; break; end
    endtask

    task automatic wait_valid(output int edges, output bit timed_out);
        edges = 0; timed_out = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.valid === 1'b1) begin edges = i; timed_out = 1'b0; break; end
        end
    endtask

    task automatic run_op(input string tag, input int av, input int nv);
        int  res, noinv, k, edges;
        bit  to;
        ref_model(av, nv, res, noinv, k);
        @(negedge clk);
        bus.a = 16'(av); bus.n = 16'(nv); bus.ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.ready = 1'b0;
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        wait_valid(edges, to);
        check({tag, "_timeout"}, 32'(to), 32'd0);
        if (to) return;
        check({tag, "_result"}, 32'(bus.result), 32'(res));
        check({tag, "_no_inverse"}, 32'(bus.no_inverse), 32'(noinv));
        check({tag, "_latency"}, 32'(edges), 32'(k + 3 + EXTRA_LAT));
`ifdef MOD_INV_CHECK_EN
        check({tag, "_check_err"}, 32'(bus.check_err), 32'd0);
`endif
        @(negedge clk);
        check({tag, "_valid_pulse"}, 32'(bus.valid), 32'd0);
        check({tag, "_hold"}, 32'(bus.result), 32'(res));
    endtask

    initial begin
        int  edges, vcount, av, nv;
        bit  to;
        reset = 1'b1;
        bus.a = '0; bus.n = '0; bus.ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_no_inverse", 32'(bus.no_inverse), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
`ifdef MOD_INV_CHECK_EN
        check("rst_check_err", 32'(bus.check_err), 32'd0);
`endif
        reset = 1'b0;

        run_op("a3_n40", 3, 40);
        run_op("a17_n3120", 17, 3120);
        run_op("a43_n40", 43, 40);
        run_op("a6_n9", 6, 9);
        run_op("n0", 1234, 0);
        run_op("n1", 77, 1);
        run_op("a0_n7", 0, 7);
        run_op("a14_n7", 14, 7);
        run_op("fib_worst", 28657, 46368);
        run_op("a1_n2", 1, 2);

        // reset in the middle of STEP
        @(negedge clk);
        bus.a = 16'd28657; bus.n = 16'd46368; bus.ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_valid", 32'(bus.valid), 32'd0);
        check("abort_result", 32'(bus.result), 32'd0);
        vcount = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.valid === 1'b1) vcount++;
        end
        check("abort_no_valid", 32'(vcount), 32'd0);
        run_op("after_abort", 3, 40);

        // ready held high: operands changed while busy must be ignored
        @(negedge clk);
        bus.a = 16'd3; bus.n = 16'd40; bus.ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.a = 16'd17; bus.n = 16'd3120;
        check("b2b_busy", 32'(bus.busy), 32'd1);
        wait_valid(edges, to);
        check("b2b_first_timeout", 32'(to), 32'd0);
        check("b2b_first_result", 32'(bus.result), 32'd27);
        check("b2b_first_latency", 32'(edges), 32'(5 + EXTRA_LAT));
        @(posedge clk);
        @(negedge clk);
        bus.ready = 1'b0;
        check("b2b_retrigger_busy", 32'(bus.busy), 32'd1);
        wait_valid(edges, to);
        check("b2b_second_timeout", 32'(to), 32'd0);
        check("b2b_second_result", 32'(bus.result), 32'd2753);
        check("b2b_second_no_inverse", 32'(bus.no_inverse), 32'd0);

        for (int i = 0; i < 16; i++) begin
            av = int'($urandom_range(0, 65535));
            nv = (i % 5 == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(2, 65535));
            run_op($sformatf("rnd%0d_a%0d_n%0d", i, av, nv), av, nv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
